// File: rtl/priority_decoder_24_seq.sv
// Buffered 2-to-4 decoder: FIFO'd codes replayed as one-hot
// patterns, each held for HOLD_CYCLES cycles, back-to-back.
module priority_decoder_24_seq #(
  parameter int HOLD_CYCLES = 2,
  parameter int FIFO_DEPTH  = 4,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    in_code,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [3:0]    out,
  output logic          out_valid,
  output logic [LW-1:0] level
);

  typedef enum logic {
    IDLE,
    DRIVE
  } state_t;

  localparam logic [3:0]    RELOAD = 4'(HOLD_CYCLES - 1);
  localparam logic [LW-1:0] FULL   = LW'(FIFO_DEPTH);

  logic [1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    out_q, out_d;
  logic          ov_q, ov_d;
  logic          push, pop, has_data;

  assign in_ready  = (level_q != FULL);
  assign push      = in_valid && in_ready;
  assign has_data  = (level_q != '0);
  assign level     = level_q;
  assign out       = out_q;
  assign out_valid = ov_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    ov_d    = ov_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (has_data) begin
          pop     = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (has_data) begin
          pop = 1'b1;
        end else begin
          out_d   = 4'b0000;
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
    if (pop) begin
      out_d = 4'b0001 << mem_q[rptr_q];
      ov_d  = 1'b1;
      cnt_d = RELOAD;
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q + LW'(push) - LW'(pop);
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
    end
  end

  // Storage needs no reset; pointers/level define validity.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wptr_q] <= in_code;
  end

endmodule

// File: tb/tb_priority_decoder_24_seq.sv
// Scoreboard bench for priority_decoder_24_seq: random and
// directed traffic against a queue-based reference model.
module tb_priority_decoder_24_seq;

  localparam int H0 = 2;
  localparam int D0 = 4;

  typedef struct {
    logic [3:0] v;
    bit         first;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] code = 2'd0;
  logic       vld = 1'b0;
  logic       rdy;
  logic [3:0] o;
  logic       ov;
  logic [2:0] lvl;
  logic [1:0] code1 = 2'd0;
  logic       vld1 = 1'b0;
  logic       rdy1;
  logic [3:0] o1;
  logic       ov1;
  logic [2:0] lvl1;

  int   vecs = 0;
  int   errs = 0;
  exp_t expq[$];
  bit   cur_acc = 1'b0;
  int   acc_done = 0;
  int   started = 0;
  bit   mon_en = 1'b0;

  priority_decoder_24_seq #(.HOLD_CYCLES(H0), .FIFO_DEPTH(D0)) u0 (
    .clk(clk), .rst(rst), .in_code(code), .in_valid(vld),
    .in_ready(rdy), .out(o), .out_valid(ov), .level(lvl)
  );

  priority_decoder_24_seq #(.HOLD_CYCLES(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .in_code(code1), .in_valid(vld1),
    .in_ready(rdy1), .out(o1), .out_valid(ov1), .level(lvl1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  always @(posedge clk) if (cur_acc) acc_done++;

  always @(negedge clk) begin
    if (mon_en) begin
      if (ov) begin
        if (expq.size() == 0) begin
          chk("sb_unexpected_out", {28'd0, o}, 32'd0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          if (e.first) started++;
          chk("sb_out", {28'd0, o}, {28'd0, e.v});
        end
      end else begin
        chk("sb_idle_zero", {28'd0, o}, 32'd0);
      end
      chk("sb_level", {29'd0, lvl}, acc_done - started);
      chk("sb_ready", {31'd0, rdy}, {31'd0, (acc_done - started) != D0});
    end
  end

  task automatic step(input bit v, input logic [1:0] c);
    vld = v;
    code = c;
    cur_acc = v && (rdy === 1'b1);
    if (cur_acc)
      for (int i = 0; i < H0; i++)
        expq.push_back('{v: 4'b0001 << c, first: (i == 0)});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 2'd0);
    rst = 1'b0;
    expq.delete();
    acc_done = 0;
    started = 0;
  endtask

  logic [3:0] seq2 [8];
  int   idx;
  int   maxl;
  bit   saw_full;
  bit   hit;

  initial begin
    seq2 = '{4'h0, 4'h8, 4'h8, 4'h1, 4'h1, 4'h2, 4'h2, 4'h0};
    @(posedge clk);
    #1;
    do_reset();
    mon_en = 1'b1;
    chk("rst_out", {28'd0, o}, 32'd0);
    chk("rst_ov", {31'd0, ov}, 32'd0);
    chk("rst_level", {29'd0, lvl}, 32'd0);
    chk("rst_ready", {31'd0, rdy}, 32'd1);

    step(1'b1, 2'd2);
    chk("t1_lat_k", {28'd0, o}, 32'd0);
    chk("t1_lvl_k", {29'd0, lvl}, 32'd1);
    step(1'b0, 2'd0);
    chk("t1_k1", {28'd0, o}, 32'h4);
    chk("t1_k1_ov", {31'd0, ov}, 32'd1);
    step(1'b0, 2'd0);
    chk("t1_k2", {28'd0, o}, 32'h4);
    step(1'b0, 2'd0);
    chk("t1_k3", {28'd0, o}, 32'd0);
    chk("t1_lvl", {29'd0, lvl}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      if (i == 0) step(1'b1, 2'd3);
      else if (i == 1) step(1'b1, 2'd0);
      else if (i == 2) step(1'b1, 2'd1);
      else step(1'b0, 2'd0);
      chk($sformatf("t2_seq%0d", i), {28'd0, o}, {28'd0, seq2[i]});
    end
    chk("t2_ov_end", {31'd0, ov}, 32'd0);

    idx = 0;
    maxl = 0;
    saw_full = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 2'(idx % 4));
      if (cur_acc) idx++;
      if (lvl > maxl) maxl = lvl;
      if (rdy === 1'b0) saw_full = 1'b1;
    end
    chk("t3_max_level", maxl, D0);
    chk("t3_saw_full", {31'd0, saw_full}, 32'd1);
    for (int i = 0; i < 20; i++) step(1'b0, 2'd0);
    chk("t3_drained", expq.size(), 32'd0);

    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      step(1'b1, 2'($urandom_range(0, 3)));
      hit = (lvl == 3) && (ov === 1'b1);
    end
    chk("t4_reached_l3", {31'd0, hit}, 32'd1);
    do_reset();
    chk("t4_out", {28'd0, o}, 32'd0);
    chk("t4_ov", {31'd0, ov}, 32'd0);
    chk("t4_lvl", {29'd0, lvl}, 32'd0);
    chk("t4_rdy", {31'd0, rdy}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 2'd0);
      chk("t4_no_stale", {28'd0, o}, 32'd0);
    end

    vld1 = 1'b1;
    code1 = 2'd1;
    step(1'b0, 2'd0);
    chk("t5_a", {28'd0, o1}, 32'd0);
    code1 = 2'd2;
    step(1'b0, 2'd0);
    chk("t5_b", {28'd0, o1}, 32'h2);
    chk("t5_lvl_b", {31'd0, lvl1 <= 3'd1}, 32'd1);
    code1 = 2'd3;
    step(1'b0, 2'd0);
    chk("t5_c", {28'd0, o1}, 32'h4);
    chk("t5_lvl_c", {31'd0, lvl1 <= 3'd1}, 32'd1);
    vld1 = 1'b0;
    step(1'b0, 2'd0);
    chk("t5_d", {28'd0, o1}, 32'h8);
    step(1'b0, 2'd0);
    chk("t5_e", {28'd0, o1}, 32'd0);
    chk("t5_ov_e", {31'd0, ov1}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      step(1'b0, 2'(i));
      chk("t6_lvl", {29'd0, lvl}, 32'd0);
      chk("t6_out", {28'd0, o}, 32'd0);
    end

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 20; i++) step(1'b0, 2'd0);
    chk("rand_drained", expq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
